// File: rtl/av_sprite_arbiter.sv
// -----------------------------------------------------------------------------
// av_sprite_arbiter
//
// Round-robin scheduler sharing one synchronous-read sprite ROM port among the
// six per-string note renderers. One request is granted per clk65 cycle. The
// granted request drives the shared ROM address. The returned pixel word is
// routed back to its requester, tagged with a one-hot rd_valid two cycles after
// the grant.
//
// Optional feature macro: AV_ARB_STATS_EN
//   defined   -> stall_cnt is a saturating 16-bit stall counter
//   undefined -> stall_cnt is tied to zero, no counter is built
//
// Ports
//   clk65       in   pixel clock (only clock)
//   reset_n     in   asynchronous active-low reset
//   hold        in   suppress new grants (in-flight reads still complete)
//   req         in   [5:0] per-requester read request (bit i = string i+1)
//   req_sprite  in   [29:0] requester i sprite index on [5i+4:5i]
//   req_addr    in   [6*AW-1:0] requester i pixel address on [AW*i+AW-1:AW*i]
//   gnt         out  [5:0] registered one-hot grant
//   mem_en      out  ROM read strobe
//   mem_sprite  out  [4:0] ROM sprite select
//   mem_addr    out  [AW-1:0] ROM pixel address
//   mem_rdata   in   [DW-1:0] ROM data, valid one cycle after mem_en
//   rd_valid    out  [5:0] one-hot data-return strobe
//   rd_data     out  [DW-1:0] returned pixel word
//   stall_cnt   out  [15:0] arbitration stall counter
// -----------------------------------------------------------------------------
module av_sprite_arbiter #(
  parameter int N_SPRITES = 18,
  parameter int AW        = 10,
  parameter int DW        = 13
) (
  input  logic            clk65,
  input  logic            reset_n,
  input  logic            hold,
  input  logic [5:0]      req,
  input  logic [29:0]     req_sprite,
  input  logic [6*AW-1:0] req_addr,
  output logic [5:0]      gnt,
  output logic            mem_en,
  output logic [4:0]      mem_sprite,
  output logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_rdata,
  output logic [5:0]      rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic [15:0]     stall_cnt
);

  localparam logic [31:0] N_SPR_L = 32'(N_SPRITES);

  logic [4:0]    sprite_arr [6];
  logic [AW-1:0] addr_arr   [6];
  logic [5:0]    elig;

  logic [2:0]    last_reg;
  logic [2:0]    win;
  logic          found;
  logic          grant_fire;
  logic [4:0]    sel_sprite;
  logic [AW-1:0] sel_addr;
  logic          sprite_ok;

  // Return pipeline: stage B holds the tag of the grant whose ROM data is
  // presented on mem_rdata this cycle, plus whether that data must be zeroed.
  logic [5:0]    tag_b_reg;
  logic          tag_b_zero_reg;

  // A requester whose grant is currently showing is masked, so a requester
  // still dropping req cannot be granted twice.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_unpack
      assign sprite_arr[gi] = req_sprite[5*gi +: 5];
      assign addr_arr[gi]   = req_addr[AW*gi +: AW];
      assign elig[gi]       = req[gi] & ~gnt[gi];
    end
  endgenerate

  // Round-robin search starting just after the last winner, wrapping 5 -> 0.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      idx = (int'(last_reg) + k) % 6;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  assign grant_fire = found & ~hold;
  assign sel_sprite = sprite_arr[win];
  assign sel_addr   = addr_arr[win];
  assign sprite_ok  = ({27'd0, sel_sprite} < N_SPR_L);

  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      last_reg       <= 3'd5;
      gnt            <= '0;
      mem_en         <= 1'b0;
      mem_sprite     <= '0;
      mem_addr       <= '0;
      tag_b_reg      <= '0;
      tag_b_zero_reg <= 1'b0;
      rd_valid       <= '0;
      rd_data        <= '0;
    end else begin
      if (grant_fire) begin
        gnt        <= 6'd1 << win;
        last_reg   <= win;
        mem_sprite <= sel_sprite;
        mem_addr   <= sel_addr;
        // Out-of-range sprites are still granted but never touch the ROM.
        mem_en     <= sprite_ok;
      end else begin
        gnt    <= '0;
        mem_en <= 1'b0;
      end

      // A grant without a ROM strobe is an invalid-sprite grant.
      tag_b_reg      <= gnt;
      tag_b_zero_reg <= ~mem_en;

      rd_valid <= tag_b_reg;
      if (|tag_b_reg) begin
        rd_data <= tag_b_zero_reg ? '0 : mem_rdata;
      end
    end
  end

`ifdef AV_ARB_STATS_EN
  logic        more_than_one;
  logic        stall_event;
  logic [15:0] stall_reg;

  // A stall is any cycle leaving an eligible requester ungranted: either hold
  // blocks everyone, or more than one is eligible and only one can win.
  assign more_than_one = |(elig & (elig - 6'd1));
  assign stall_event   = (|elig) & (hold | more_than_one);

  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      stall_reg <= '0;
    end else if (stall_event && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule
